sub_64_seq: RTL and testbench

//   Multi-cycle 64-bit two's-complement subtractor for the y86-64 ALU (SUBQ/CMP path).

---
 rtl/sub_64_seq_if.sv | 32 +++
 rtl/sub_64_seq.sv | 127 ++++++++++++
 tb/tb_sub_64_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sub_64_seq_if.sv
//------------------------------------------------------------------------------
// Module  : sub_64_seq_if
// Brief   : start/busy/done handshake and operand/result bundle for sub_64_seq.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sub_64_seq_if #(
  parameter int N = 64
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         zf;
  logic         sf;
  logic         of;

  modport master (
    output start, a, b,
    input  busy, done, diff, zf, sf, of
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, zf, sf, of
  );
endinterface

`default_nettype wire

// File: rtl/sub_64_seq.sv
//------------------------------------------------------------------------------
// Module  : sub_64_seq
// Brief   : Multi-cycle a - b (a + ~b + 1), CHUNK bits per clock, with y86 ZF/SF/OF.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sub_64_seq #(
  parameter int N     = 64,
  parameter int CHUNK = 16
) (
  input  logic          clk,
  input  logic          rst,
  sub_64_seq_if.slave   io_bus
);

  localparam int NCHUNK = N / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] C_S_IDLE = 2'd0;
  localparam logic [1:0] C_S_RUN  = 2'd1;
  localparam logic [1:0] C_S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [N-1:0]     r_partial;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [N-1:0]     r_diff;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;

  logic [CHUNK-1:0] w_a_chk;
  logic [CHUNK-1:0] w_b_chk;
  logic [CHUNK:0]   w_sum;
  logic [N-1:0]     w_full;
  logic             w_last;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;

  assign w_accept = (r_state == C_S_IDLE) && io_bus.start;
  assign w_last   = (r_idx == C_LAST_IDX);
  assign w_a_chk  = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_chk  = r_b[r_idx*CHUNK +: CHUNK];
  assign w_sum    = {1'b0, w_a_chk} + {1'b0, ~w_b_chk} + {{CHUNK{1'b0}}, r_carry};

  // Result as it will look once the chunk in flight lands in the partial register.
  always_comb begin
    w_full                        = r_partial;
    w_full[r_idx*CHUNK +: CHUNK]  = w_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_S_IDLE: if (io_bus.start) w_state_nxt = C_S_RUN;
      C_S_RUN:  if (w_last)       w_state_nxt = C_S_DONE;
      C_S_DONE:                   w_state_nxt = C_S_IDLE;
      default:                    w_state_nxt = C_S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      C_S_RUN:  w_busy = 1'b1;
      C_S_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_partial <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b1;
      r_diff    <= '0;
      r_zf      <= 1'b0;
      r_sf      <= 1'b0;
      r_of      <= 1'b0;
    end else if (w_accept) begin
      r_a     <= io_bus.a;
      r_b     <= io_bus.b;
      r_carry <= 1'b1;
      r_idx   <= '0;
    end else if (r_state == C_S_RUN) begin
      r_partial[r_idx*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      r_carry                         <= w_sum[CHUNK];
      r_idx                           <= r_idx + C_IDX_ONE;
      // Final carry-out is dropped: y86 has no CF.
      if (w_last) begin
        r_diff <= w_full;
        r_zf   <= (w_full == '0);
        r_sf   <= w_full[N-1];
        r_of   <= (r_a[N-1] != r_b[N-1]) && (w_full[N-1] != r_a[N-1]);
      end
    end
  end

  assign io_bus.busy = w_busy;
  assign io_bus.done = w_done;
  assign io_bus.diff = r_diff;
  assign io_bus.zf   = r_zf;
  assign io_bus.sf   = r_sf;
  assign io_bus.of   = r_of;

endmodule

`default_nettype wire

// File: tb/tb_sub_64_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_sub_64_seq
// Brief   : Directed self-checking bench for sub_64_seq with a cycle-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sub_64_seq;

  localparam int N      = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = N / CHUNK;

  logic clk;
  logic rst;

  sub_64_seq_if #(.N(N)) bus ();

  sub_64_seq #(.N(N), .CHUNK(CHUNK)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: ops take NCHUNK+1 edges from acceptance to leaving DONE; results from plain subtraction.
  int           m_cnt   = 0;
  bit           m_valid = 0;
  logic [N-1:0] m_pa, m_pb, m_diff;
  logic         m_zf, m_sf, m_of;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      m_diff  = '0;
      m_zf    = 0;
      m_sf    = 0;
      m_of    = 0;
      m_valid = 1;
    end else if (m_cnt == 0) begin
      if (bus.start) begin
        m_cnt = NCHUNK + 1;
        m_pa  = bus.a;
        m_pb  = bus.b;
      end
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 1) begin
        m_diff = m_pa - m_pb;
        m_zf   = (m_diff == '0);
        m_sf   = m_diff[N-1];
        m_of   = (m_pa[N-1] != m_pb[N-1]) && (m_diff[N-1] != m_pa[N-1]);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", N'(bus.busy), N'(m_cnt > 1));
      chk("done", N'(bus.done), N'(m_cnt == 1));
      chk("diff", bus.diff, m_diff);
      chk("zf",   N'(bus.zf), N'(m_zf));
      chk("sf",   N'(bus.sf), N'(m_sf));
      chk("of",   N'(bus.of), N'(m_of));
    end
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] ed, input logic ez, input logic es,
                        input logic eo, input bit glitch);
    int k;
    int nb;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    k  = 1;
    nb = bus.busy ? 1 : 0;
    while (!bus.done && k < 20) begin
      if (glitch && k == 2) begin
        bus.start = 1'b1;
        bus.a     = '0;
        bus.b     = 64'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (bus.busy) nb++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: no done after %0d cycles, want done after %0d", k, NCHUNK + 1);
    end else begin
      chk("latency",   N'(k),  N'(NCHUNK + 1));
      chk("busy_len",  N'(nb), N'(NCHUNK));
      chk("lit_diff",  bus.diff, ed);
      chk("lit_zf",    N'(bus.zf), N'(ez));
      chk("lit_sf",    N'(bus.sf), N'(es));
      chk("lit_of",    N'(bus.of), N'(eo));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no end, want end");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", N'(bus.busy), '0);
    chk("rst_done", N'(bus.done), '0);
    chk("rst_diff", bus.diff, '0);
    chk("rst_flags", N'({bus.zf, bus.sf, bus.of}), '0);

    run_op(64'd10, 64'd3, 64'd7, 0, 0, 0, 0);
    run_op(64'd5,  64'd5, 64'd0, 1, 0, 0, 0);
    run_op(64'd3,  64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 0, 1, 0, 0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 0);
    run_op(64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1, 1, 0);
    run_op(64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1, 1, 0);
    // Restart and operand changes while busy must not disturb the op in flight.
    run_op(64'd100, 64'd1, 64'd99, 0, 0, 0, 1);

    // Abort an op after two chunks have been processed.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 64'h1234;
    bus.b     = 64'h34;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  N'(bus.busy), '0);
    chk("abort_done",  N'(bus.done), '0);
    chk("abort_diff",  bus.diff, '0);
    chk("abort_flags", N'({bus.zf, bus.sf, bus.of}), '0);
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    chk("abort_no_done", N'(seen_done), '0);

    run_op(64'hDEAD_BEEF_0000_0000, 64'd1, 64'hDEAD_BEEE_FFFF_FFFF, 0, 1, 0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
